// File: rtl/mrisc_ctrl_pkg.sv
// ============================================================================
// Package : mrisc_ctrl_pkg
// Purpose : Shared encodings for the multicycle control unit. It holds the
//           FSM state encoding, the instruction class and branch sub-op codes,
//           the ALUinSel and PCSrc encodings, flag bit positions and the
//           control-word bundle that the top-level decoder drives.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mrisc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction classes, taken from opcode[5:3]
  localparam logic [2:0] CLS_ALU_REG = 3'b000;
  localparam logic [2:0] CLS_ALU_IMM = 3'b001;
  localparam logic [2:0] CLS_LOAD    = 3'b010;
  localparam logic [2:0] CLS_STORE   = 3'b011;
  localparam logic [2:0] CLS_BRANCH  = 3'b100;
  localparam logic [2:0] CLS_CALL    = 3'b101;
  localparam logic [2:0] CLS_RETURN  = 3'b110;
  localparam logic [2:0] CLS_MISC    = 3'b111;

  // Within the misc class, only sub-op 111 means HALT; everything else is a NOP
  localparam logic [2:0] SUB_HALT    = 3'b111;

  // Branch condition sub-ops; 110 and 111 are never taken
  localparam logic [2:0] BR_ALWAYS   = 3'b000;
  localparam logic [2:0] BR_Z        = 3'b001;
  localparam logic [2:0] BR_NZ       = 3'b010;
  localparam logic [2:0] BR_S        = 3'b011;
  localparam logic [2:0] BR_NS       = 3'b100;
  localparam logic [2:0] BR_C        = 3'b101;

  // ALU operand-select encodings
  localparam logic [1:0] AIN_REG_REG   = 2'b00;
  localparam logic [1:0] AIN_REG_IMM   = 2'b01;
  localparam logic [1:0] AIN_REG_SHAMT = 2'b10;
  localparam logic [1:0] AIN_PC_OFF    = 2'b11;

  // PC source encodings
  localparam logic [1:0] PCS_INC     = 2'b00;
  localparam logic [1:0] PCS_BRANCH  = 2'b01;
  localparam logic [1:0] PCS_REG     = 2'b10;

  // Bit positions inside the {carry, sign, zero} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       data_pc_sel;
    logic       reg_select;
    logic [2:0] alu_op;
    logic [1:0] alu_in_sel;
    logic       halted;
  } ctrl_t;

  function automatic logic is_alu_class(input logic [2:0] cls);
    return (cls == CLS_ALU_REG) || (cls == CLS_ALU_IMM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// Module  : branch_cond_eval
// Purpose : Combinational branch-condition evaluator. It resolves a branch
//           sub-op against the latched ALU flags.
// Ports   : i_subop   [2:0] branch condition sub-op
//           i_flags_q [2:0] latched flags {carry, sign, zero}
//           o_taken         1 when the branch is taken
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond_eval
  import mrisc_ctrl_pkg::*;
(
  input  logic [2:0] i_subop,
  input  logic [2:0] i_flags_q,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_subop)
      BR_ALWAYS: o_taken = 1'b1;
      BR_Z:      o_taken = i_flags_q[FLAG_Z];
      BR_NZ:     o_taken = ~i_flags_q[FLAG_Z];
      BR_S:      o_taken = i_flags_q[FLAG_S];
      BR_NS:     o_taken = ~i_flags_q[FLAG_S];
      BR_C:      o_taken = i_flags_q[FLAG_C];
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module  : multicycle_control_unit
// Purpose : Moore-style control FSM for a small multicycle RISC datapath
//           (FETCH, DECODE, EXEC, MEM, WB, HALT). The opcode is latched into
//           an internal IR copy at the end of FETCH, and only that copy is
//           decoded.
// Ports   : clk, reset (async, active-low)
//           opcode[OPW-1:0], flags[2:0] {carry, sign, zero}
//           RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect,
//           ALUop[2:0], ALUinSel[1:0], IRWrite, PCWrite, PCSrc[1:0], halted
//           step_req (only when CTRL_SINGLE_STEP_EN is defined)
// Config  : CTRL_SINGLE_STEP_EN - FETCH waits for step_req before latching IR
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
  import mrisc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic           step_req,
`endif
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     flags,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           DataPCSel,
  output logic           RegSelect,
  output logic [2:0]     ALUop,
  output logic [1:0]     ALUinSel,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic [1:0]     PCSrc,
  output logic           halted
);

  state_t         r_state;
  logic [OPW-1:0] r_ir;
  logic [2:0]     r_flags_q;

  logic [2:0]     w_cls;
  logic [2:0]     w_sub;
  logic           w_taken;
  logic           w_fetch_go;
  ctrl_t          w_ctl;
  ctrl_t          w_ctl_out;

  assign w_cls = r_ir[5:3];
  assign w_sub = r_ir[2:0];

`ifdef CTRL_SINGLE_STEP_EN
  assign w_fetch_go = step_req;
`else
  assign w_fetch_go = 1'b1;
`endif

  branch_cond_eval u_branch_cond_eval (
    .i_subop   (w_sub),
    .i_flags_q (r_flags_q),
    .o_taken   (w_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_flags_q <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_fetch_go) begin
            r_ir    <= opcode;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if ((w_cls == CLS_MISC) && (w_sub == SUB_HALT)) r_state <= S_HALT;
          else                                            r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_alu_class(w_cls)) begin
            // Only ALU results update the condition flags that branches see
            r_flags_q <= flags;
            r_state   <= S_WB;
          end else if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM:   r_state <= (w_cls == CLS_LOAD) ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Control word derived from the registered state, IR copy and flags_q only
  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_FETCH:  w_ctl.ir_write = w_fetch_go;
      S_DECODE: w_ctl = '0;
      S_EXEC: begin
        case (w_cls)
          CLS_ALU_REG, CLS_ALU_IMM: begin
            w_ctl.alu_op     = w_sub;
            w_ctl.alu_in_sel = (w_cls == CLS_ALU_IMM) ? AIN_REG_IMM : AIN_REG_REG;
          end
          CLS_LOAD, CLS_STORE: begin
            w_ctl.alu_op     = 3'b000;
            w_ctl.alu_in_sel = AIN_REG_IMM;
          end
          CLS_BRANCH: begin
            w_ctl.alu_in_sel = AIN_PC_OFF;
            w_ctl.pc_write   = 1'b1;
            w_ctl.pc_src     = w_taken ? PCS_BRANCH : PCS_INC;
          end
          CLS_CALL: begin
            w_ctl.reg_write   = 1'b1;
            w_ctl.data_pc_sel = 1'b1;
            w_ctl.reg_select  = 1'b1;
            w_ctl.pc_write    = 1'b1;
            w_ctl.pc_src      = PCS_BRANCH;
          end
          CLS_RETURN: begin
            w_ctl.pc_write = 1'b1;
            w_ctl.pc_src   = PCS_REG;
          end
          default: begin
            // Misc NOP: only advance the PC
            w_ctl.pc_write = 1'b1;
            w_ctl.pc_src   = PCS_INC;
          end
        endcase
      end
      S_MEM: begin
        if (w_cls == CLS_LOAD) begin
          w_ctl.mem_read = 1'b1;
        end else begin
          // The store completes in MEM, so that is where its PC update lands
          w_ctl.mem_write = 1'b1;
          w_ctl.pc_write  = 1'b1;
          w_ctl.pc_src    = PCS_INC;
        end
      end
      S_WB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = (w_cls == CLS_LOAD);
        w_ctl.pc_write   = 1'b1;
        w_ctl.pc_src     = PCS_INC;
      end
      S_HALT:  w_ctl.halted = 1'b1;
      default: w_ctl = '0;
    endcase
  end

  // The FSM sits in FETCH during reset, so the outputs are forced low
  // directly from the reset pin, independent of the clock.
  assign w_ctl_out = reset ? w_ctl : '0;

  assign IRWrite   = w_ctl_out.ir_write;
  assign PCWrite   = w_ctl_out.pc_write;
  assign PCSrc     = w_ctl_out.pc_src;
  assign RegWrite  = w_ctl_out.reg_write;
  assign MemRead   = w_ctl_out.mem_read;
  assign MemWrite  = w_ctl_out.mem_write;
  assign MemtoReg  = w_ctl_out.mem_to_reg;
  assign DataPCSel = w_ctl_out.data_pc_sel;
  assign RegSelect = w_ctl_out.reg_select;
  assign ALUop     = w_ctl_out.alu_op;
  assign ALUinSel  = w_ctl_out.alu_in_sel;
  assign halted    = w_ctl_out.halted;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module  : tb_multicycle_control_unit
// Purpose : Self-checking bench for multicycle_control_unit. Each instruction
//           is expanded by a behavioural model into its expected per-cycle
//           control vectors and compared cycle by cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [2:0] flags;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step_req;
`endif
  logic       RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect;
  logic [2:0] ALUop;
  logic [1:0] ALUinSel;
  logic       IRWrite, PCWrite, halted;
  logic [1:0] PCSrc;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] model_fq = 3'b000;   // model of the flags latched by the last ALU op

  multicycle_control_unit #(.OPW(6)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CTRL_SINGLE_STEP_EN
    .step_req  (step_req),
`endif
    .opcode    (opcode),
    .flags     (flags),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemtoReg  (MemtoReg),
    .DataPCSel (DataPCSel),
    .RegSelect (RegSelect),
    .ALUop     (ALUop),
    .ALUinSel  (ALUinSel),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {IRW, PCW, PCSrc, RW, MR, MW, M2R, DPS, RS, ALUop, ALUin, halt}
  logic [15:0] obs;
  assign obs = {IRWrite, PCWrite, PCSrc, RegWrite, MemRead, MemWrite, MemtoReg,
                DataPCSel, RegSelect, ALUop, ALUinSel, halted};

  function automatic logic [15:0] mk(input logic irw, input logic pcw, input logic [1:0] pcs,
                                     input logic rw, input logic mr, input logic mw,
                                     input logic m2r, input logic dps, input logic rs,
                                     input logic [2:0] aop, input logic [1:0] ain,
                                     input logic h);
    return {irw, pcw, pcs, rw, mr, mw, m2r, dps, rs, aop, ain, h};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Branch outcome from the condition table, using named flags
  function automatic logic br_taken(input logic [2:0] sub, input logic [2:0] fq);
    logic c, s, z;
    {c, s, z} = fq;
    case (sub)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s;
      3'd4: return !s;
      3'd5: return c;
      default: return 1'b0;
    endcase
  endfunction

  // Entered inside a FETCH cycle before its falling edge; returns #1 after the
  // rising edge that lands in the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [2:0] fl);
    logic [15:0] exp_q[$];
    logic [2:0]  cls, sub;
    int          npcw;
    cls = op[5:3];
    sub = op[2:0];
    opcode = op;
    flags  = fl;
    exp_q.push_back(mk(1,0,2'b00,0,0,0,0,0,0,3'd0,2'b00,0));   // FETCH
    exp_q.push_back(16'h0000);                                  // DECODE
    case (cls)
      3'd0, 3'd1: begin
        exp_q.push_back(mk(0,0,2'b00,0,0,0,0,0,0,sub,(cls == 3'd1) ? 2'b01 : 2'b00,0));
        exp_q.push_back(mk(0,1,2'b00,1,0,0,0,0,0,3'd0,2'b00,0));
      end
      3'd2: begin
        exp_q.push_back(mk(0,0,2'b00,0,0,0,0,0,0,3'd0,2'b01,0));
        exp_q.push_back(mk(0,0,2'b00,0,1,0,0,0,0,3'd0,2'b00,0));
        exp_q.push_back(mk(0,1,2'b00,1,0,0,1,0,0,3'd0,2'b00,0));
      end
      3'd3: begin
        exp_q.push_back(mk(0,0,2'b00,0,0,0,0,0,0,3'd0,2'b01,0));
        exp_q.push_back(mk(0,1,2'b00,0,0,1,0,0,0,3'd0,2'b00,0));
      end
      3'd4: exp_q.push_back(mk(0,1,br_taken(sub, model_fq) ? 2'b01 : 2'b00,
                               0,0,0,0,0,0,3'd0,2'b11,0));
      3'd5: exp_q.push_back(mk(0,1,2'b01,1,0,0,0,1,1,3'd0,2'b00,0));
      3'd6: exp_q.push_back(mk(0,1,2'b10,0,0,0,0,0,0,3'd0,2'b00,0));
      default: exp_q.push_back(mk(0,1,2'b00,0,0,0,0,0,0,3'd0,2'b00,0));
    endcase
    npcw = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk($sformatf("op%02o_cyc%0d", op, i), 32'(obs), 32'(exp_q[i]));
      chk("mem_excl", 32'(MemRead & MemWrite), 32'd0);
      if (PCWrite) npcw++;
      @(posedge clk);
      #1;
      // Scramble the opcode bus once IR has been latched
      if (i == 0) opcode = 6'($urandom);
    end
    chk($sformatf("pcw_once_op%02o", op), 32'(npcw), 32'd1);
    if (cls == 3'd0 || cls == 3'd1) model_fq = fl;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rop;
    reset  = 1'b0;
    opcode = 6'o00;
    flags  = 3'b000;
`ifdef CTRL_SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 32'(obs), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed sequences
    run_instr(6'o01, 3'b000);   // reg ALU
    run_instr(6'o11, 3'b100);   // imm ALU
    run_instr(6'o20, 3'b000);   // load
    run_instr(6'o30, 3'b000);   // store
    run_instr(6'o00, 3'b001);   // ALU sets Z
    run_instr(6'o41, 3'b000);   // branch on Z: taken
    run_instr(6'o00, 3'b000);   // ALU clears Z
    run_instr(6'o41, 3'b111);   // branch on Z: not taken
    run_instr(6'o46, 3'b111);   // never taken
    run_instr(6'o20, 3'b111);   // load leaves flags_q alone
    run_instr(6'o42, 3'b000);   // !Z: taken
    run_instr(6'o50, 3'b000);   // call
    run_instr(6'o60, 3'b000);   // return
    run_instr(6'o70, 3'b000);   // misc NOP

    // Randomized instruction stream (HALT excluded)
    for (int k = 0; k < 200; k++) begin
      rop = 6'($urandom);
      if (rop == 6'o77) rop = 6'o70;
      run_instr(rop, 3'($urandom));
    end

    // Reset mid-instruction aborts it
    opcode = 6'o20;
    @(negedge clk);
    chk("abort_fetch", 32'(obs), 32'(mk(1,0,2'b00,0,0,0,0,0,0,3'd0,2'b00,0)));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("abort_rst_zero", 32'(obs), 32'd0);
    @(posedge clk);
    #1 chk("abort_rst_hold", 32'(obs), 32'd0);
    #2 reset = 1'b1;
    model_fq = 3'b000;
    run_instr(6'o43, 3'b000);   // flags_q cleared: S=0 so not taken
    run_instr(6'o44, 3'b000);   // !S: taken

    // HALT holds until reset
    opcode = 6'o77;
    @(negedge clk);
    chk("halt_fetch", 32'(obs), 32'(mk(1,0,2'b00,0,0,0,0,0,0,3'd0,2'b00,0)));
    @(posedge clk);
    #1 opcode = 6'o00;
    @(negedge clk);
    chk("halt_decode", 32'(obs), 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("halted_cyc%0d", k), 32'(obs), 32'(mk(0,0,2'b00,0,0,0,0,0,0,3'd0,2'b00,1)));
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("halt_rst_zero", 32'(obs), 32'd0);
    #2 reset = 1'b1;
    model_fq = 3'b000;
    run_instr(6'o01, 3'b010);
    run_instr(6'o43, 3'b000);   // S latched by the previous ALU op: taken

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port opcode  input  OPW  current instruction opcode: [5:3] class, [2:0] sub-op.
REQ-005 SHALL have port flags  input  3  datapath ALU flags {carry, sign, zero}.
REQ-006 SHALL have ports RegWrite, MemRead, MemWrite, MemtoReg, DataPCSel, RegSelect  output  1 each  datapath controls.
REQ-007 SHALL have ports ALUop  output  3  and ALUinSel  output  2: 00 reg/reg, 01 reg/imm, 10 reg/shamt, 11 PC/offset.
REQ-008 SHALL have ports IRWrite  output  1, PCWrite  output  1, and PCSrc  output  2: 00 PC+1, 01 branch target, 10 register.
REQ-009 SHALL have port halted  output  1, high while in HALT.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB and HALT; outputs depend only on state, the latched class/sub-op and flags_q.
REQ-011 SHALL latch opcode into an internal IR copy at the end of FETCH (IRWrite=1 in FETCH only) and decode only that copy.
REQ-012 Classes: 000 ALU reg, 001 ALU imm, 010 load, 011 store, 100 branch, 101 call, 110 return, 111 misc (111111 = HALT; all others NOP).
REQ-013 Transitions: FETCH->DECODE->EXEC; ALU classes EXEC->WB->FETCH (4 cycles); load EXEC->MEM->WB->FETCH (5); store EXEC->MEM->FETCH (4); branch, call, return and NOP EXEC->FETCH (3); HALT DECODE->HALT, held until reset.
REQ-014 EXEC for ALU classes: ALUop=sub-op, ALUinSel=00 (class 000) or 01 (class 001); for load/store: ALUop=000 (add), ALUinSel=01.
REQ-015 SHALL capture flags into flags_q on the EXEC->WB edge of ALU classes only; other classes leave flags_q unchanged.
REQ-016 Branch sub-op conditions on flags_q: 000 always, 001 Z, 010 !Z, 011 S, 100 !S, 101 C; 110/111 never taken.
REQ-017 Branch EXEC: ALUinSel=11; PCWrite=1; PCSrc=01 if taken, else 00.
REQ-018 Call EXEC: RegWrite=1, DataPCSel=1, RegSelect=1 (link register), PCWrite=1, PCSrc=01. Return EXEC: PCWrite=1, PCSrc=10.
REQ-019 MEM: MemRead=1 for load; for store, MemWrite=1, PCWrite=1, PCSrc=00.
REQ-020 WB: RegWrite=1, MemtoReg=1 for load and 0 for ALU classes; PCWrite=1, PCSrc=00.
REQ-021 NOP EXEC: PCWrite=1, PCSrc=00 only; all other outputs SHALL be 0.
REQ-022 PCWrite SHALL be asserted exactly one cycle per instruction; MemRead and MemWrite SHALL never be high together.

Reset
REQ-023 While reset=0: state=FETCH, IR=0, flags_q=0, all outputs 0 regardless of clk.
REQ-024 Reset asserted mid-instruction SHALL abort it; the first rising edge after release SHALL leave FETCH.
REQ-025 HALT SHALL be exited only by reset.

Configuration
REQ-026 Macro CTRL_SINGLE_STEP_EN defined: adds port step_req  input  1; FETCH holds (IRWrite=0) until step_req=1 at a rising edge. Undefined: no port; FETCH lasts exactly one cycle.

Structure
REQ-027 Package mrisc_ctrl_pkg SHALL hold state encoding, class codes, branch sub-op codes, and ALUinSel/PCSrc encodings.
REQ-028 Sub-module branch_cond_eval (combinational: sub-op, flags_q -> taken) SHALL be used.

Verification
REQ-029 Reg-ALU opcode 000001 after reset -> FETCH,DECODE,EXEC(ALUop=001,ALUinSel=00),WB(RegWrite=1,MemtoReg=0,PCWrite=1) -> FETCH; 4 cycles.
REQ-030 Load 010000 -> MEM cycle MemRead=1, WB MemtoReg=1 RegWrite=1; 5 cycles. Store 011000 -> MEM MemWrite=1 PCWrite=1; 4 cycles.
REQ-031 ALU op with flags=001 then branch 100001 -> EXEC PCSrc=01; same with flags=000 -> PCSrc=00; branch 100110 -> PCSrc=00 always.
REQ-032 Call 101000 -> EXEC RegWrite=DataPCSel=RegSelect=1, PCSrc=01; return 110000 -> PCSrc=10.
REQ-033 Opcode 111111 -> halted=1, all other outputs 0 for 10+ cycles; reset pulse low 3 ns mid-HALT -> FETCH, halted=0.
REQ-034 With CTRL_SINGLE_STEP_EN, step_req=0 for 5 cycles -> FETCH held, IRWrite=0; step_req=1 -> IRWrite=1 one cycle, then DECODE.
